// File: rtl/branch_comp_seq.sv
// Multi-cycle branch comparator: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU one CHUNK_WIDTH slice per cycle, MSB first.
// Optional macro BRANCH_COMP_SEQ_EARLY_EXIT_EN: finish on the first differing slice instead of after all slices.

module branch_comp_slice #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic          ne,
  output logic          lt
);
  assign ne = (a != b);
  assign lt = (a < b);
endmodule

module branch_comp_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [2:0]            funct3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  branch,
  output logic                  illegal
);
  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDXW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] a, b;
  logic [2:0]            f;
  logic [IDXW-1:0]       idx;
  logic                  diff_found, lt;

  // Slice views of the captured operands, one comparator per slice.
  logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] a_s, b_s;
  logic [NUM_CHUNKS-1:0]                  s_ne, s_lt;

  assign a_s = a;
  assign b_s = b;

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_slice
    branch_comp_slice #(.CW(CHUNK_WIDTH)) u_slice (
      .a  (a_s[g]),
      .b  (b_s[g]),
      .ne (s_ne[g]),
      .lt (s_lt[g])
    );
  end

  // Signed compares become unsigned by flipping both sign bits at capture.
  logic                  sgn;
  logic [DATA_WIDTH-1:0] a_cap, b_cap;

  always_comb begin
    sgn   = funct3[2] & ~funct3[1];
    a_cap = op1;
    b_cap = op2;
    a_cap[DATA_WIDTH-1] = op1[DATA_WIDTH-1] ^ sgn;
    b_cap[DATA_WIDTH-1] = op2[DATA_WIDTH-1] ^ sgn;
  end

  // Next-state of the running compare, including the slice examined this cycle.
  logic hit, diff_nx, lt_nx, last, br_nx, ill_nx;

  always_comb begin
    hit     = ~diff_found & s_ne[idx];
    diff_nx = diff_found | hit;
    lt_nx   = hit ? s_lt[idx] : lt;
`ifdef BRANCH_COMP_SEQ_EARLY_EXIT_EN
    last    = (idx == '0) | hit;
`else
    last    = (idx == '0);
`endif
    ill_nx  = (f == 3'b010) | (f == 3'b011);
    br_nx   = 1'b0;
    case (f)
      3'b000:         br_nx = ~diff_nx;
      3'b001:         br_nx = diff_nx;
      3'b100, 3'b110: br_nx = lt_nx;
      3'b101, 3'b111: br_nx = ~lt_nx;
      default:        br_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      branch     <= 1'b0;
      illegal    <= 1'b0;
      a          <= '0;
      b          <= '0;
      f          <= '0;
      idx        <= '0;
      diff_found <= 1'b0;
      lt         <= 1'b0;
    end else if (flush) begin
      // Abort wins over capture and the result handshake; branch/illegal keep their last values.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a          <= a_cap;
            b          <= b_cap;
            f          <= funct3;
            idx        <= IDX_TOP;
            diff_found <= 1'b0;
            lt         <= 1'b0;
            in_ready   <= 1'b0;
            state      <= CMP;
          end
        end
        CMP: begin
          diff_found <= diff_nx;
          lt         <= lt_nx;
          if (last) begin
            branch    <= br_nx;
            illegal   <= ill_nx;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_branch_comp_seq.sv
// Directed bench for branch_comp_seq: vector table plus hand sequences for backpressure, flush and reset.

module tb_branch_comp_seq;
  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, branch, illegal;
  logic [31:0] op1, op2;
  logic [2:0]  funct3;

  int total = 0;
  int passed = 0;

  branch_comp_seq #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .funct3    (funct3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .branch    (branch),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  fn;
    logic        br;
    logic        ill;
    int          lat_ee;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Capture on the next edge, then count edges until out_valid (0 on timeout).
  task automatic do_req(input logic [31:0] o1, input logic [31:0] o2, input logic [2:0] fn,
                        output int lat);
    op1 = o1; op2 = o2; funct3 = fn; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  function automatic int exp_lat(input int lat_ee);
`ifdef BRANCH_COMP_SEQ_EARLY_EXIT_EN
    return lat_ee;
`else
    return 4;
`endif
  endfunction

  initial begin
    int   lat;
    logic seen;

    vt[0]  = '{32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 1'b1, 1'b0, 4};
    vt[1]  = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 1'b1, 1'b0, 1};
    vt[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 1'b0, 1'b0, 1};
    vt[3]  = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 1'b1, 1'b0, 1};
    vt[4]  = '{32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b0, 1'b1, 1};
    vt[5]  = '{32'h12345678, 32'h12345679, 3'b001, 1'b1, 1'b0, 4};
    vt[6]  = '{32'h00000005, 32'h00000005, 3'b101, 1'b1, 1'b0, 4};
    vt[7]  = '{32'h01000000, 32'h02000000, 3'b110, 1'b1, 1'b0, 1};
    vt[8]  = '{32'hAABBCCDD, 32'hAABBCCDE, 3'b000, 1'b0, 1'b0, 4};
    vt[9]  = '{32'h80000000, 32'h7FFFFFFF, 3'b101, 1'b0, 1'b0, 1};
    vt[10] = '{32'h7FFFFFFF, 32'h80000000, 3'b100, 1'b0, 1'b0, 1};
    vt[11] = '{32'h00000000, 32'h00000000, 3'b001, 1'b0, 1'b0, 4};
    vt[12] = '{32'h00010000, 32'h00020000, 3'b111, 1'b0, 1'b0, 2};
    vt[13] = '{32'h0000ABCD, 32'h0000ABCD, 3'b011, 1'b0, 1'b1, 4};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; funct3 = '0;
    #12;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset branch", int'(branch), 0);
    chk("reset illegal", int'(illegal), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      do_req(vt[i].op1, vt[i].op2, vt[i].fn, lat);
      chk($sformatf("vec%0d latency", i), lat, exp_lat(vt[i].lat_ee));
      chk($sformatf("vec%0d branch", i), int'(branch), int'(vt[i].br));
      chk($sformatf("vec%0d illegal", i), int'(illegal), int'(vt[i].ill));
      chk($sformatf("vec%0d in_ready busy", i), int'(in_ready), 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid after hs", i), int'(out_valid), 0);
      chk($sformatf("vec%0d in_ready after hs", i), int'(in_ready), 1);
    end

    // Backpressure: result must hold for five stalled cycles.
    out_ready = 1'b0;
    do_req(32'h12345678, 32'h12345679, 3'b001, lat);
    chk("bp latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp out_valid held", int'(out_valid), 1);
      chk("bp branch held", int'(branch), 1);
      chk("bp in_ready low", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp out_valid after hs", int'(out_valid), 0);
    chk("bp in_ready after hs", int'(in_ready), 1);

    // Flush two cycles into CMP: result never appears.
    op1 = 32'h7; op2 = 32'h7; funct3 = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush cmp in_ready", int'(in_ready), 1);
    chk("flush cmp out_valid", int'(out_valid), 0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush cmp no result", int'(seen), 0);

    // Flush in IDLE with in_valid: request must not be captured.
    op1 = 32'h1; op2 = 32'h2; funct3 = 3'b110; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    chk("flush idle in_ready", int'(in_ready), 1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush idle no result", int'(seen), 0);

    do_req(32'h5, 32'h5, 3'b101, lat);
    chk("post flush latency", lat, 4);
    chk("post flush branch", int'(branch), 1);
    @(posedge clk); #1;

    // Flush in DONE drops the result but branch keeps its value.
    out_ready = 1'b0;
    do_req(32'h1, 32'h1, 3'b000, lat);
    chk("done flush latency", lat, 4);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("done flush out_valid", int'(out_valid), 0);
    chk("done flush in_ready", int'(in_ready), 1);
    chk("done flush branch held", int'(branch), 1);
    out_ready = 1'b1;

    // Asynchronous reset in the middle of CMP.
    op1 = 32'h3; op2 = 32'h3; funct3 = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid reset in_ready", int'(in_ready), 1);
    chk("mid reset out_valid", int'(out_valid), 0);
    chk("mid reset branch", int'(branch), 0);
    chk("mid reset illegal", int'(illegal), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_req(32'h1, 32'h2, 3'b110, lat);
    chk("after reset latency", lat, exp_lat(4));
    chk("after reset branch", int'(branch), 1);
    @(posedge clk); #1;
    chk("after reset in_ready", int'(in_ready), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
